risc_sequencer: RTL and testbench

- Instruction-cycle sequencer for the 8-bit VeriRisc datapath. It sits directly upstream of the 32x8 Memory block and drives its rd/wr strobes, the address-mux select and the datapath load/enable controls.
- An internal 3-bit phase counter steps through 8 phases per instruction. Control outputs are decoded from the current phase, the instruction-register opcode and the accumulator zero flag.
- A sticky halt state stops sequencing when a HLT opcode is executed.

---
 rtl/risc_pkg.sv | 29 ++
 rtl/risc_sequencer_phase_counter.sv | 23 ++
 rtl/risc_sequencer.sv | 112 +++++++++++
 tb/tb_risc_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared opcode and phase encodings for the VeriRisc instruction-cycle sequencer.
`default_nettype none

package risc_pkg;

  localparam int OPWIDTH_DEFAULT = 3;

  // Opcode values; compared after casting to the instruction-register width
  localparam int HLT = 0;
  localparam int SKZ = 1;
  localparam int ADD = 2;
  localparam int AND = 3;
  localparam int XOR = 4;
  localparam int LDA = 5;
  localparam int STO = 6;
  localparam int JMP = 7;

  localparam logic [2:0] INST_ADDR  = 3'd0;
  localparam logic [2:0] INST_FETCH = 3'd1;
  localparam logic [2:0] INST_LOAD  = 3'd2;
  localparam logic [2:0] IDLE       = 3'd3;
  localparam logic [2:0] OP_ADDR    = 3'd4;
  localparam logic [2:0] OP_FETCH   = 3'd5;
  localparam logic [2:0] ALU_OP     = 3'd6;
  localparam logic [2:0] STORE      = 3'd7;

endpackage

`default_nettype wire

// File: rtl/risc_sequencer_phase_counter.sv
// Free-running 3-bit instruction phase counter with advance enable and sticky hold.
`default_nettype none

module phase_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       hold,
  output logic [2:0] phase
);

  // Wraps 7 -> 0 through natural 3-bit overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= 3'd0;
    end else if (en && !hold) begin
      phase <= phase + 3'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/risc_sequencer.sv
// VeriRisc sequencer: steps 8 phases per instruction and decodes memory/datapath strobes.
`default_nettype none

module risc_sequencer
  import risc_pkg::*;
#(
  parameter int OPWIDTH = OPWIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_en,
  input  logic [OPWIDTH-1:0] opcode,
  input  logic               zero,
  output logic [2:0]         phase,
  output logic               sel,
  output logic               rd,
  output logic               wr,
  output logic               ld_ir,
  output logic               ld_ac,
  output logic               ld_pc,
  output logic               inc_pc,
  output logic               data_e,
  output logic               halt
);

  logic halted;
  logic op_hlt;
  logic op_skz;
  logic op_sto;
  logic op_jmp;
  logic op_alu;

  assign op_hlt = (opcode == OPWIDTH'(HLT));
  assign op_skz = (opcode == OPWIDTH'(SKZ));
  assign op_sto = (opcode == OPWIDTH'(STO));
  assign op_jmp = (opcode == OPWIDTH'(JMP));
  assign op_alu = (opcode == OPWIDTH'(ADD)) || (opcode == OPWIDTH'(AND)) ||
                  (opcode == OPWIDTH'(XOR)) || (opcode == OPWIDTH'(LDA));

  phase_counter u_phase_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (step_en),
    .hold  (halted),
    .phase (phase)
  );

  // The counter's own increment carries phase 4 -> 5 on the halting edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (!halted && step_en && (phase == OP_ADDR) && op_hlt) begin
      halted <= 1'b1;
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted) begin
      halt = 1'b1;
    end else begin
      case (phase)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = op_hlt;
        end
        OP_FETCH: begin
          rd = op_alu;
        end
        ALU_OP: begin
          rd     = op_alu;
          inc_pc = op_skz && zero;
          ld_pc  = op_jmp;
          data_e = op_sto;
        end
        STORE: begin
          rd     = op_alu;
          ld_ac  = op_alu;
          ld_pc  = op_jmp;
          wr     = op_sto;
          data_e = op_sto;
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_risc_sequencer.sv
// Self-checking scoreboard bench for risc_sequencer.
`default_nettype none

module tb_risc_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step_en = 1'b0;
  logic [2:0] opcode = 3'd5;
  logic       zero = 1'b0;
  logic [2:0] phase;
  logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;

  int vectors = 0;
  int miscompares = 0;

  logic [2:0] m_phase = 3'd0;
  logic       m_halted = 1'b0;

  typedef struct packed {
    logic [2:0] ph;
    logic [8:0] ctl;
  } exp_t;
  exp_t sb[$];

  risc_sequencer #(.OPWIDTH(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .step_en (step_en),
    .opcode  (opcode),
    .zero    (zero),
    .phase   (phase),
    .sel     (sel),
    .rd      (rd),
    .wr      (wr),
    .ld_ir   (ld_ir),
    .ld_ac   (ld_ac),
    .ld_pc   (ld_pc),
    .inc_pc  (inc_pc),
    .data_e  (data_e),
    .halt    (halt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    assert (!(rd && data_e)) else $error("rd and data_e both high in phase %0d", phase);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Control vector order: sel rd wr ld_ir ld_ac ld_pc inc_pc data_e halt
  function automatic logic [8:0] model_ctl(input logic [2:0] p, input logic h,
                                           input logic [2:0] op, input logic z);
    logic alu;
    logic [8:0] v;
    alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    v = '0;
    if (h) begin
      v[0] = 1'b1;
    end else begin
      v[8] = (p <= 3'd3);
      v[7] = (p >= 3'd1 && p <= 3'd3) || (p >= 3'd5 && alu);
      v[6] = (p == 3'd7) && (op == 3'd6);
      v[5] = (p == 3'd2) || (p == 3'd3);
      v[4] = (p == 3'd7) && alu;
      v[3] = (p >= 3'd6) && (op == 3'd7);
      v[2] = (p == 3'd4) || ((p == 3'd6) && (op == 3'd1) && z);
      v[1] = (p >= 3'd6) && (op == 3'd6);
      v[0] = (p == 3'd4) && (op == 3'd0);
    end
    return v;
  endfunction

  task automatic check_now(input string tag);
    exp_t e;
    sb.push_back('{ph: m_phase, ctl: model_ctl(m_phase, m_halted, opcode, zero)});
    e = sb.pop_front();
    check({tag, "_phase"}, 16'(phase), 16'(e.ph));
    check({tag, "_ctl"}, 16'({sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt}), 16'(e.ctl));
    check({tag, "_rd_de"}, 16'(rd & data_e), 16'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst && !m_halted && step_en) begin
      if (m_phase == 3'd4 && opcode == 3'd0) m_halted = 1'b1;
      m_phase = m_phase + 3'd1;
    end
    #1;
  endtask

  task automatic run_instr(input logic [2:0] op, input logic z, input string tag);
    opcode = op;
    zero   = z;
    for (int i = 0; i < 8; i++) begin
      check_now(tag);
      tick();
    end
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    m_phase  = 3'd0;
    m_halted = 1'b0;
    check_now(tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_now("reset");
    @(negedge clk);
    rst = 1'b0;
    step_en = 1'b1;
    #1;
    check_now("released");

    run_instr(3'd5, 1'b0, "lda");
    run_instr(3'd6, 1'b0, "sto");
    run_instr(3'd1, 1'b1, "skz_z1");
    run_instr(3'd1, 1'b0, "skz_z0");
    run_instr(3'd7, 1'b0, "jmp");
    run_instr(3'd2, 1'b1, "add");
    run_instr(3'd3, 1'b0, "and");
    run_instr(3'd4, 1'b1, "xor");

    // Freeze at phase 3, then resume
    opcode = 3'd5;
    zero   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_now("pre_hold");
      tick();
    end
    step_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_now("hold");
      tick();
    end
    check_now("hold_end");
    step_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_now("resume");
    end

    // HLT: halts after the phase-4 edge and ignores step_en
    opcode = 3'd0;
    for (int i = 0; i < 5; i++) begin
      check_now("hlt_pre");
      tick();
    end
    check_now("hlt_entered");
    for (int i = 0; i < 20; i++) begin
      tick();
      check_now("halted");
    end
    async_reset("hlt_rst");

    // Reset in the middle of a store phase
    opcode = 3'd6;
    for (int i = 0; i < 7; i++) begin
      check_now("sto_pre");
      tick();
    end
    check_now("sto_ph7");
    async_reset("sto_rst");
    run_instr(3'd5, 1'b0, "post_rst");

    if (sb.size() != 0) check("sb_empty", 16'(sb.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    miscompares++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
